mem_access_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the execute stage; consumes its registered outputs (ALU result, store data, control) and feeds writeback.
- Performs loads and stores against a data-memory port with a req/ack handshake.
- Aligns loads and stores for byte and halfword accesses, big-endian.
- Stalls upstream while an access is outstanding, and provides the MEM-stage forwarding value back to execute.

---
 rtl/mem_access_stage_pkg.sv | 31 +++
 rtl/mem_align.sv | 68 ++++++
 rtl/mem_access_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: load/store operation codes, FSM state
// and access-size types, and big-endian byte-lane numbering.
package mem_access_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h30;
    localparam logic [5:0] OP_LBU = 6'h31;
    localparam logic [5:0] OP_LH  = 6'h32;
    localparam logic [5:0] OP_LHU = 6'h33;
    localparam logic [5:0] OP_LW  = 6'h34;
    localparam logic [5:0] OP_SB  = 6'h38;
    localparam logic [5:0] OP_SH  = 6'h39;
    localparam logic [5:0] OP_SW  = 6'h3A;

    // Lane 0 is the most significant byte of the word.
    localparam logic [1:0] BYTE_LANE0 = 2'd0;
    localparam logic [1:0] BYTE_LANE1 = 2'd1;
    localparam logic [1:0] BYTE_LANE2 = 2'd2;
    localparam logic [1:0] BYTE_LANE3 = 2'd3;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } size_t;

endpackage

// File: rtl/mem_align.sv
// Combinational big-endian alignment: store byte-enables/lane replication,
// load lane extraction with sign/zero extension, and the misaligned flag.
module mem_align
    import mem_access_stage_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    size_t       size;
    logic        sext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        size = SzWord;
        sext = 1'b0;
        case (op)
            OP_LB:          begin size = SzByte; sext = 1'b1; end
            OP_LBU, OP_SB:  size = SzByte;
            OP_LH:          begin size = SzHalf; sext = 1'b1; end
            OP_LHU, OP_SH:  size = SzHalf;
            OP_LW, OP_SW:   size = SzWord;
            default:        size = SzWord;
        endcase
    end

    always_comb begin
        unique case (addr_lo)
            BYTE_LANE0: byte_v = rdata[31:24];
            BYTE_LANE1: byte_v = rdata[23:16];
            BYTE_LANE2: byte_v = rdata[15:8];
            BYTE_LANE3: byte_v = rdata[7:0];
        endcase
    end

    assign half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (size)
            SzByte: begin
                be        = 4'b1000 >> addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = sext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            SzHalf: begin
                be         = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{store_data[15:0]}};
                load_data  = sext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues aligned loads/stores over a req/ack port, stalls
// upstream while busy. Optional BUSY timeout enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
`ifdef MEM_ACCESS_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        STALL_OUT,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT,
    output logic        Misaligned_OUT,
`ifdef MEM_ACCESS_TIMEOUT_EN
    output logic        Timeout_OUT,
`endif
    output logic [31:0] Mem_result_forward
);

    state_t      state_q;
    logic [31:0] addr_q, wdata_q, instr_q, pc_q;
    logic [3:0]  be_q;
    logic [5:0]  op_q;
    logic [4:0]  wreg_q;
    logic        we_q, rw_q;

    logic        busy, mem_op, misaligned, start, timeout_hit;
    logic [5:0]  align_op;
    logic [1:0]  align_lo;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_c;

    assign busy   = (state_q == BUSY);
    assign mem_op = MemRead1_IN | MemWrite1_IN;
    // Store path works on the live inputs in IDLE, load path on the latched op in BUSY.
    assign align_op = busy ? op_q : ALU_Control1_IN;
    assign align_lo = busy ? addr_q[1:0] : ALU_result1_IN[1:0];
    assign start    = !busy && mem_op && !misaligned;

    mem_align u_align (
        .op         (align_op),
        .addr_lo    (align_lo),
        .store_data (MemWriteData1_IN),
        .rdata      (dmem_rdata),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_c),
        .misaligned (misaligned)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign STALL_OUT          = busy ? (!dmem_ack && !timeout_hit) : start;
    assign dmem_req           = busy;
    assign dmem_we            = we_q;
    assign dmem_addr          = {addr_q[31:2], 2'b00};
    assign dmem_be            = be_q;
    assign dmem_wdata         = wdata_q;
    assign Mem_result_forward = WriteData1_OUT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            wdata_q            <= '0;
            instr_q            <= '0;
            pc_q               <= '0;
            be_q               <= '0;
            op_q               <= '0;
            wreg_q             <= '0;
            we_q               <= 1'b0;
            rw_q               <= 1'b0;
            Instr1_OUT         <= '0;
            Instr1_PC_OUT      <= '0;
            WriteData1_OUT     <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            Misaligned_OUT     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q              <= '0;
            Timeout_OUT        <= 1'b0;
`endif
        end else begin
            Misaligned_OUT <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            Timeout_OUT    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        RegWrite1_OUT  <= 1'b0;
                        Misaligned_OUT <= misaligned;
                        if (!misaligned) begin
                            state_q <= BUSY;
                            addr_q  <= ALU_result1_IN;
                            wdata_q <= wdata_c;
                            be_q    <= be_c;
                            we_q    <= MemWrite1_IN;
                            op_q    <= ALU_Control1_IN;
                            instr_q <= Instr1_IN;
                            pc_q    <= Instr1_PC_IN;
                            wreg_q  <= WriteRegister1_IN;
                            rw_q    <= RegWrite1_IN;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end else begin
                        Instr1_OUT         <= Instr1_IN;
                        Instr1_PC_OUT      <= Instr1_PC_IN;
                        WriteData1_OUT     <= ALU_result1_IN;
                        WriteRegister1_OUT <= WriteRegister1_IN;
                        RegWrite1_OUT      <= RegWrite1_IN;
                    end
                end
                BUSY: begin
                    RegWrite1_OUT <= 1'b0;
                    if (dmem_ack) begin
                        state_q            <= IDLE;
                        Instr1_OUT         <= instr_q;
                        Instr1_PC_OUT      <= pc_q;
                        WriteData1_OUT     <= we_q ? addr_q : load_c;
                        WriteRegister1_OUT <= wreg_q;
                        RegWrite1_OUT      <= rw_q;
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        Timeout_OUT <= 1'b1;
`endif
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed table-driven bench for mem_access_stage with a small ack responder.
module tb_mem_access_stage;

    logic        CLK, RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
    logic [4:0]  WriteRegister1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
    logic [5:0]  ALU_Control1_IN;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        STALL_OUT, RegWrite1_OUT, Misaligned_OUT;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, Mem_result_forward;
    logic [4:0]  WriteRegister1_OUT;

    int checks = 0;
    int errors = 0;

    mem_access_stage dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Instr1_IN          (Instr1_IN),
        .Instr1_PC_IN       (Instr1_PC_IN),
        .ALU_result1_IN     (ALU_result1_IN),
        .WriteRegister1_IN  (WriteRegister1_IN),
        .MemWriteData1_IN   (MemWriteData1_IN),
        .RegWrite1_IN       (RegWrite1_IN),
        .ALU_Control1_IN    (ALU_Control1_IN),
        .MemRead1_IN        (MemRead1_IN),
        .MemWrite1_IN       (MemWrite1_IN),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .STALL_OUT          (STALL_OUT),
        .Instr1_OUT         (Instr1_OUT),
        .Instr1_PC_OUT      (Instr1_PC_OUT),
        .WriteData1_OUT     (WriteData1_OUT),
        .WriteRegister1_OUT (WriteRegister1_OUT),
        .RegWrite1_OUT      (RegWrite1_OUT),
        .Misaligned_OUT     (Misaligned_OUT),
        .Mem_result_forward (Mem_result_forward)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        logic        rd, wr, rw;
        logic [4:0]  wreg;
        logic [31:0] alu, data, rdata;
        int          ack_wait;
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic        chk_be;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_res;
        logic [31:0] res;
        logic        rw_exp, mis;
        int          stalls;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(string nm, logic [5:0] ctrl, logic rd, logic wr, logic rw,
                                logic [4:0] wreg, logic [31:0] alu, logic [31:0] data,
                                logic [31:0] rdata, int ack_wait, logic req, logic [31:0] addr,
                                logic we, logic chk_be, logic [3:0] be, logic [31:0] wdata,
                                logic chk_res, logic [31:0] res, logic rw_exp, logic mis,
                                int stalls);
        vec_t v;
        v.name = nm; v.ctrl = ctrl; v.rd = rd; v.wr = wr; v.rw = rw; v.wreg = wreg;
        v.alu = alu; v.data = data; v.rdata = rdata; v.ack_wait = ack_wait; v.req = req;
        v.addr = addr; v.we = we; v.chk_be = chk_be; v.be = be; v.wdata = wdata;
        v.chk_res = chk_res; v.res = res; v.rw_exp = rw_exp; v.mis = mis; v.stalls = stalls;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_nop();
        ALU_Control1_IN = 6'h00; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0; RegWrite1_IN = 1'b0;
        ALU_result1_IN = '0; MemWriteData1_IN = '0; WriteRegister1_IN = '0;
        Instr1_IN = '0; Instr1_PC_IN = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   busy_n, stalls, guard;
        logic done, req_seen;
        logic [31:0] instr;
        instr = 32'hA000_0000 | 32'(idx);
        @(negedge CLK);
        ALU_Control1_IN = v.ctrl; MemRead1_IN = v.rd; MemWrite1_IN = v.wr;
        RegWrite1_IN = v.rw; WriteRegister1_IN = v.wreg; ALU_result1_IN = v.alu;
        MemWriteData1_IN = v.data; Instr1_IN = instr; Instr1_PC_IN = 32'h1000 + 32'(idx * 4);
        dmem_ack = 1'b0;
        busy_n = 0; stalls = 0; guard = 0; done = 1'b0; req_seen = 1'b0;
        while (!done && guard < 40) begin
            if (guard > 0) @(negedge CLK);
            if (dmem_req) begin
                busy_n++;
                req_seen = 1'b1;
                chk({v.name, "_addr"}, dmem_addr, v.addr);
                chk({v.name, "_we"}, 32'(dmem_we), 32'(v.we));
                if (v.chk_be) begin
                    chk({v.name, "_be"}, 32'(dmem_be), 32'(v.be));
                    chk({v.name, "_wdata"}, dmem_wdata, v.wdata);
                end
                // Upstream values change while busy; the stage must use its latched copy.
                ALU_result1_IN = ~v.alu; MemWriteData1_IN = ~v.data; WriteRegister1_IN = ~v.wreg;
                RegWrite1_IN = ~v.rw; ALU_Control1_IN = 6'h00; Instr1_IN = ~instr;
                MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
                dmem_ack = (busy_n == v.ack_wait + 1);
                dmem_rdata = v.rdata;
            end else begin
                dmem_ack = 1'b0;
            end
            #1;
            if (STALL_OUT) stalls++;
            done = !STALL_OUT;
            @(posedge CLK); #1;
            guard++;
            if (!done) chk({v.name, "_bubble_rw"}, 32'(RegWrite1_OUT), 32'd0);
        end
        dmem_ack = 1'b0;
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s_timeout: stall still 1 after %0d cycles, required release", v.name,
                     guard);
        end
        chk({v.name, "_req_seen"}, 32'(req_seen), 32'(v.req));
        chk({v.name, "_stalls"}, 32'(stalls), 32'(v.stalls));
        chk({v.name, "_regwrite"}, 32'(RegWrite1_OUT), 32'(v.rw_exp));
        chk({v.name, "_misaligned"}, 32'(Misaligned_OUT), 32'(v.mis));
        if (v.chk_res) begin
            chk({v.name, "_wdata_out"}, WriteData1_OUT, v.res);
            chk({v.name, "_forward"}, Mem_result_forward, v.res);
            chk({v.name, "_wreg"}, 32'(WriteRegister1_OUT), 32'(v.wreg));
            chk({v.name, "_instr"}, Instr1_OUT, instr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        drive_nop();

        vecs[0]  = mk("nop", 6'h20, 0, 0, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 32'h0000_1234, 1, 0, 0);
        vecs[1]  = mk("lb", 6'h30, 1, 0, 1, 7, 32'h0000_0101, 0, 32'h11F2_3344, 3,
                      1, 32'h0000_0100, 0, 0, 0, 0, 1, 32'hFFFF_FFF2, 1, 0, 4);
        vecs[2]  = mk("lbu", 6'h31, 1, 0, 1, 7, 32'h0000_0101, 0, 32'h11F2_3344, 0,
                      1, 32'h0000_0100, 0, 0, 0, 0, 1, 32'h0000_00F2, 1, 0, 1);
        vecs[3]  = mk("lh", 6'h32, 1, 0, 1, 8, 32'h0000_0102, 0, 32'h11F2_8344, 1,
                      1, 32'h0000_0100, 0, 0, 0, 0, 1, 32'hFFFF_8344, 1, 0, 2);
        vecs[4]  = mk("lhu", 6'h33, 1, 0, 1, 8, 32'h0000_0100, 0, 32'h11F2_8344, 0,
                      1, 32'h0000_0100, 0, 0, 0, 0, 1, 32'h0000_11F2, 1, 0, 1);
        vecs[5]  = mk("lw", 6'h34, 1, 0, 1, 9, 32'h0000_0008, 0, 32'hDEAD_BEEF, 2,
                      1, 32'h0000_0008, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 3);
        vecs[6]  = mk("sh", 6'h39, 0, 1, 0, 0, 32'h0000_0202, 32'h0000_ABCD, 0, 1,
                      1, 32'h0000_0200, 1, 1, 4'b0011, 32'hABCD_ABCD, 0, 0, 0, 0, 2);
        vecs[7]  = mk("sb3", 6'h38, 0, 1, 0, 0, 32'h0000_0303, 32'h1234_5678, 0, 0,
                      1, 32'h0000_0300, 1, 1, 4'b0001, 32'h7878_7878, 0, 0, 0, 0, 1);
        vecs[8]  = mk("sb0_rw", 6'h38, 0, 1, 1, 6, 32'h0000_0300, 32'h0000_00AB, 0, 2,
                      1, 32'h0000_0300, 1, 1, 4'b1000, 32'hABAB_ABAB, 0, 0, 1, 0, 3);
        vecs[9]  = mk("sw", 6'h3A, 0, 1, 0, 0, 32'h0000_0010, 32'hCAFE_F00D, 0, 1,
                      1, 32'h0000_0010, 1, 1, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0, 2);
        vecs[10] = mk("lw_mis", 6'h34, 1, 0, 1, 3, 32'h0000_0006, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[11] = mk("nop2", 6'h00, 0, 0, 1, 4, 32'h8765_4321, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 1, 32'h8765_4321, 1, 0, 0);
        vecs[12] = mk("sh_mis", 6'h39, 0, 1, 0, 0, 32'h0000_0201, 32'h1111_2222, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[13] = mk("lhu_mis", 6'h33, 1, 0, 1, 2, 32'h0000_0003, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[14] = mk("lb3", 6'h30, 1, 0, 1, 11, 32'h0000_0003, 0, 32'h11F2_3380, 0,
                      1, 32'h0000_0000, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 1, 0, 1);
        vecs[15] = mk("other_word", 6'h3F, 1, 0, 1, 10, 32'h0000_0004, 0, 32'h0102_0304, 0,
                      1, 32'h0000_0004, 0, 0, 0, 0, 1, 32'h0102_0304, 1, 0, 1);
        vecs[16] = mk("lh0", 6'h32, 1, 0, 1, 12, 32'h0000_0000, 0, 32'h8001_7FFF, 0,
                      1, 32'h0000_0000, 0, 0, 0, 0, 1, 32'hFFFF_8001, 1, 0, 1);
        vecs[17] = mk("lbu2", 6'h31, 1, 0, 1, 13, 32'h0000_00A2, 0, 32'h1122_C344, 1,
                      1, 32'h0000_00A0, 0, 0, 0, 0, 1, 32'h0000_00C3, 1, 0, 2);

        #12;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(STALL_OUT), 32'd0);
        chk("rst_wdata_out", WriteData1_OUT, 32'd0);
        chk("rst_regwrite", 32'(RegWrite1_OUT), 32'd0);
        chk("rst_mis", 32'(Misaligned_OUT), 32'd0);
        chk("rst_instr", Instr1_OUT, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Ack while IDLE must be ignored.
        @(negedge CLK);
        drive_nop();
        ALU_result1_IN = 32'h0000_55AA; RegWrite1_IN = 1'b1; WriteRegister1_IN = 5'd3;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_ack_req", 32'(dmem_req), 32'd0);
        chk("idle_ack_stall", 32'(STALL_OUT), 32'd0);
        @(posedge CLK); #1;
        chk("idle_ack_result", WriteData1_OUT, 32'h0000_55AA);
        chk("idle_ack_state", 32'(dmem_req), 32'd0);
        dmem_ack = 1'b0;

        // Reset in the middle of an access abandons it.
        @(negedge CLK);
        drive_nop();
        ALU_Control1_IN = 6'h34; MemRead1_IN = 1'b1; RegWrite1_IN = 1'b1;
        ALU_result1_IN = 32'h0000_0040; WriteRegister1_IN = 5'd9;
        @(negedge CLK);
        chk("rst_busy_req_before", 32'(dmem_req), 32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_busy_req", 32'(dmem_req), 32'd0);
        chk("rst_busy_wdata_out", WriteData1_OUT, 32'd0);
        chk("rst_busy_regwrite", 32'(RegWrite1_OUT), 32'd0);
        chk("rst_busy_wreg", 32'(WriteRegister1_OUT), 32'd0);
        chk("rst_busy_mis", 32'(Misaligned_OUT), 32'd0);
        drive_nop();
        @(negedge CLK);
        RESET = 1'b1;
        run_vec(mk("lw_after_rst", 6'h34, 1, 0, 1, 14, 32'h0000_0040, 0, 32'h0BAD_F00D, 1,
                   1, 32'h0000_0040, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 1, 0, 2), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
